// File: rtl/vector_mem_responder_pkg.sv
// vector_mem_pkg: shared types and helpers for the vector memory responder.
//   state_t   - responder FSM states
//   LANES     - byte lanes per vector
//   LANE_W    - lane width in bits
//   VEC_W     - full vector width
//   IDX_W     - width of a lane index
//   lane_sel  - extract one lane from a vector
package vector_mem_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int IDX_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [LANE_W-1:0] lane_sel(input logic [VEC_W-1:0] vec,
                                                 input logic [IDX_W-1:0] idx);
    return vec[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/vector_mem_responder_read_tag_pipe.sv
// read_tag_pipe: DEPTH-deep shift register of {valid, lane index} that tracks
// each outstanding RAM read so the returning byte lands in the right lane.
//   clk, reset        - clock, async active-low reset (all stages invalid)
//   in_valid, in_idx  - tag for the read issued this cycle
//   out_valid, out_idx - tag whose data is on mem_q this cycle
module read_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld;
  logic [IDX_W-1:0] idx [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) idx[k] <= '0;
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_idx;
      for (int k = 1; k < DEPTH; k++) begin
        vld[k] <= vld[k-1];
        idx[k] <= idx[k-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/vector_mem_responder.sv
// vector_mem_responder: serialises one 128-bit vector load/store into 16
// byte accesses on an 8-bit RAM port and returns data or a write ack.
//
// state | meaning
// IDLE  | ready for a request, RAM port quiet
// WRITE | one lane written per cycle, base+0 .. base+15
// READ  | reads issued per cycle, captured READ_LATENCY cycles later
// RESP  | response held until rsp_ready
//
// Ports:
//   clk, reset                         - clock, async active-low reset
//   req_valid/ready/write/addr/wdata   - request channel
//   rsp_valid/ready/write/rdata        - response channel
//   mem_address/data/wren, mem_q       - byte-wide synchronous RAM port
//   busy                               - any state other than IDLE
module vector_mem_responder
  import vector_mem_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [VEC_W-1:0]  rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LANE_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [LANE_W-1:0] mem_q,
  output logic              busy
);

  // One extra bit so the issue counter can sit at LANES once issuing is done.
  localparam int CNT_W = IDX_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [VEC_W-1:0]  wdata;
  logic [VEC_W-1:0]  rdata;
  logic              write_q;
  logic [CNT_W-1:0]  cnt;

  logic              issue;
  logic              tag_valid;
  logic [IDX_W-1:0]  tag_idx;

  assign issue = (state == READ) && (cnt < CNT_W'(LANES));

  read_tag_pipe #(
    .DEPTH(READ_LATENCY),
    .IDX_W(IDX_W)
  ) u_read_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (issue),
    .in_idx   (cnt[IDX_W-1:0]),
    .out_valid(tag_valid),
    .out_idx  (tag_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      base    <= '0;
      wdata   <= '0;
      rdata   <= '0;
      write_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            base    <= req_addr;
            wdata   <= req_wdata;
            write_q <= req_write;
            cnt     <= '0;
            // Stores must answer with all-zero data; loads overwrite every lane.
            rdata   <= '0;
            state   <= req_write ? WRITE : READ;
          end
        end
        WRITE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(LANES - 1)) state <= RESP;
        end
        READ: begin
          if (issue) cnt <= cnt + 1'b1;
          if (tag_valid) begin
            rdata[tag_idx*LANE_W +: LANE_W] <= mem_q;
            if (tag_idx == IDX_W'(LANES - 1)) state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port decoded only from registered state, so a reset drops mem_wren at once.
  always_comb begin
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    if (state == WRITE) begin
      mem_wren    = 1'b1;
      mem_address = base + ADDR_W'(cnt);
      mem_data    = lane_sel(wdata, cnt[IDX_W-1:0]);
    end else if (state == READ) begin
      mem_address = issue ? (base + ADDR_W'(cnt)) : base;
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata;

endmodule

// File: tb/tb_vector_mem_responder.sv
// Directed bench for vector_mem_responder: three instances (READ_LATENCY 1..3)
// each with its own ideal synchronous RAM model.
module tb_vector_mem_responder;

  localparam logic [127:0] VEC_A   = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [127:0] VEC_B   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] VEC_C   = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] VEC_D   = 128'h5F5E5D5C5B5A59585756555453525150;
  localparam logic [127:0] VEC_MIX = 128'hAFAEADACABAAA9A8A7A6A5_5453525150;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_write;
  logic [7:0]   req_addr;
  logic [127:0] req_wdata;
  logic         req_valid   [3];
  logic         req_ready   [3];
  logic         rsp_valid   [3];
  logic         rsp_ready   [3];
  logic         rsp_write   [3];
  logic [127:0] rsp_rdata   [3];
  logic [7:0]   mem_address [3];
  logic [7:0]   mem_data    [3];
  logic         mem_wren    [3];
  logic [7:0]   mem_q       [3];
  logic         busy        [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    logic [7:0] ram [256];
    logic [7:0] qd  [3];

    always @(posedge clk) begin
      if (mem_wren[g]) ram[mem_address[g]] <= mem_data[g];
      qd[0] <= ram[mem_address[g]];
      qd[1] <= qd[0];
      qd[2] <= qd[1];
    end

    assign mem_q[g] = qd[g];

    vector_mem_responder #(
      .ADDR_W      (8),
      .READ_LATENCY(g + 1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_write  (rsp_write[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .mem_address(mem_address[g]),
      .mem_data   (mem_data[g]),
      .mem_wren   (mem_wren[g]),
      .mem_q      (mem_q[g]),
      .busy       (busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Store with rsp_ready held high: checks every lane write and the one-cycle ack.
  task automatic do_store(input int g, input logic [7:0] base, input logic [127:0] data);
    logic [7:0] a;
    req_write    = 1'b1;
    req_addr     = base;
    req_wdata    = data;
    req_valid[g] = 1'b1;
    step();
    req_valid[g] = 1'b0;
    req_wdata    = '1;
    req_addr     = 8'h55;
    for (int k = 0; k < 16; k++) begin
      a = base + 8'(k);
      check("st_wren", mem_wren[g], 1);
      check("st_addr", mem_address[g], a);
      check("st_data", mem_data[g], data[8*k +: 8]);
      step();
    end
    check("ack_valid", rsp_valid[g], 1);
    check("ack_write", rsp_write[g], 1);
    check("ack_rdata", rsp_rdata[g], 0);
    check("ack_wren", mem_wren[g], 0);
    step();
    check("ack_done", rsp_valid[g], 0);
    check("ack_ready", req_ready[g], 1);
  endtask

  // Called in cycle 1 after a load was accepted; counts cycles to rsp_valid.
  task automatic wait_load(input int g, input int lat, input logic [127:0] exp);
    int cyc;
    cyc = 1;
    while (!rsp_valid[g] && cyc < 40) begin
      step();
      cyc++;
    end
    check("ld_latency", cyc, 17 + lat);
    check("ld_rdata", rsp_rdata[g], exp);
    check("ld_write", rsp_write[g], 0);
  endtask

  task automatic do_load(input int g, input logic [7:0] base, input int lat,
                         input logic [127:0] exp);
    req_write    = 1'b0;
    req_addr     = base;
    req_valid[g] = 1'b1;
    step();
    req_valid[g] = 1'b0;
    req_addr     = 8'h55;
    check("ld_addr0", mem_address[g], base);
    wait_load(g, lat, exp);
    step();
    check("ld_done", rsp_valid[g], 0);
  endtask

  initial begin
    reset     = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int g = 0; g < 3; g++) begin
      req_valid[g] = 1'b0;
      rsp_ready[g] = 1'b1;
    end
    step();
    step();

    check("rst_req_ready", req_ready[0], 1);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_wren", mem_wren[0], 0);
    check("rst_addr", mem_address[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_rdata", rsp_rdata[0], 0);
    reset = 1'b1;
    step();
    check("idle_ready", req_ready[0], 1);

    // store then load at 0x10
    do_store(0, 8'h10, VEC_A);
    check("ram_10", gen_dut[0].ram[8'h10], 8'hA0);
    check("ram_1f", gen_dut[0].ram[8'h1F], 8'hAF);
    do_load(0, 8'h10, 1, VEC_A);

    // wrap-around store at 0xF8
    do_store(0, 8'hF8, VEC_B);
    check("ram_f8", gen_dut[0].ram[8'hF8], 8'h00);
    check("ram_ff", gen_dut[0].ram[8'hFF], 8'h07);
    check("ram_00", gen_dut[0].ram[8'h00], 8'h08);
    check("ram_07", gen_dut[0].ram[8'h07], 8'h0F);

    // backpressure: load 0x10 held in RESP while a load of 0xF8 waits
    rsp_ready[0] = 1'b0;
    req_write    = 1'b0;
    req_addr     = 8'h10;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    wait_load(0, 1, VEC_A);
    req_addr     = 8'hF8;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", rsp_valid[0], 1);
      check("bp_rdata", rsp_rdata[0], VEC_A);
      check("bp_ready", req_ready[0], 0);
    end
    rsp_ready[0] = 1'b1;
    step();
    check("hs_valid", rsp_valid[0], 0);
    check("hs_ready", req_ready[0], 1);
    step();
    check("bp_accept", busy[0], 1);
    req_valid[0] = 1'b0;
    req_addr     = 8'h55;
    wait_load(0, 1, VEC_B);
    step();

    // latency sweep on the deeper-latency instances
    for (int g = 1; g < 3; g++) begin
      do_store(g, 8'h40, VEC_C);
      do_load(g, 8'h40, g + 1, VEC_C);
    end

    // reset while lane 5 of a store is on the port
    req_write    = 1'b1;
    req_addr     = 8'h10;
    req_wdata    = VEC_D;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    repeat (5) step();
    check("rm_addr", mem_address[0], 8'h15);
    check("rm_wren_pre", mem_wren[0], 1);
    #2;
    reset = 1'b0;
    #1;
    check("rm_wren", mem_wren[0], 0);
    check("rm_ready", req_ready[0], 1);
    check("rm_valid", rsp_valid[0], 0);
    check("rm_busy", busy[0], 0);
    step();
    reset = 1'b1;
    step();
    check("rm_ram_10", gen_dut[0].ram[8'h10], 8'h50);
    check("rm_ram_14", gen_dut[0].ram[8'h14], 8'h54);
    check("rm_ram_15", gen_dut[0].ram[8'h15], 8'hA5);
    check("rm_ram_1f", gen_dut[0].ram[8'h1F], 8'hAF);
    do_load(0, 8'h10, 1, VEC_MIX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
